pe_row_sequencer: RTL

- Controller that sequences one PE (ifmap/filter/psum scratchpads plus registered MAC) through one 1-D row convolution.
- Loads an ifmap row (W words) and a filter row (S words) from an upstream valid/ready stream, then clears the psum pad.
- Runs E = W-S+1 outputs x S taps of MAC with psum write-back, and streams each finished output downstream.
- Sits between the array-level scheduler/buffers and a single PE instance; drives every PE control/address/write port.

---
 rtl/pe_row_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pe_row_sequencer.sv
// pe_row_sequencer: drives one PE through a single 1-D row convolution.
// A job loads W ifmap words and then S filter words from the input stream.
// It clears E = W-S+1 psum entries and runs E x S MAC taps with psum write-back.
// Each finished output is streamed downstream.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, cfg_w, cfg_s       job request and row/filter lengths (sampled in IDLE)
//   in_valid/in_ready/in_data load stream (ifmap words, then filter words)
//   out_valid/out_ready/...   result stream
//   busy, done, cfg_err       status (done and cfg_err are one-cycle pulses)
//   pe_*                      PE control, address and scratchpad write ports
module pe_row_sequencer #(
   parameter int unsigned IF_DEPTH   = 12,
   parameter int unsigned PSUM_DEPTH = 24,
   parameter int unsigned DW         = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [3:0]    cfg_w,
   input  logic [3:0]    cfg_s,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          busy,
   output logic          done,
   output logic          cfg_err,
   output logic          pe_en,
   output logic [3:0]    pe_addr_ifmap,
   output logic [7:0]    pe_addr_filter,
   output logic [4:0]    pe_addr_psum,
   output logic          pe_wr_en_ifmap,
   output logic [DW-1:0] pe_input_ifmap,
   output logic          pe_wr_en_filter,
   output logic [DW-1:0] pe_input_filter,
   output logic          pe_wr_en_psum,
   output logic [DW-1:0] pe_input_psum,
   input  logic [DW-1:0] pe_output_psum
);

   typedef enum logic [2:0] {
      StIdle, StLoadIf, StLoadFlt, StClr, StMac, StWb, StDone
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] w_q, w_d, s_q, s_d, e_len_q, e_len_d;
   logic [3:0] cnt_q, cnt_d, e_q, e_d, tap_q, tap_d;
   logic       cfg_err_q, cfg_err_d;
   logic       cfg_bad;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         w_q       <= '0;
         s_q       <= '0;
         e_len_q   <= '0;
         cnt_q     <= '0;
         e_q       <= '0;
         tap_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         w_q       <= w_d;
         s_q       <= s_d;
         e_len_q   <= e_len_d;
         cnt_q     <= cnt_d;
         e_q       <= e_d;
         tap_q     <= tap_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // E never exceeds W, so bounding W by the psum pad keeps every psum address in range.
   assign cfg_bad = (cfg_w == 4'd0) || (cfg_s == 4'd0) || (cfg_s > cfg_w) ||
                    (32'(cfg_w) > IF_DEPTH) || (32'(cfg_w) > PSUM_DEPTH);

   assign busy    = (state_q != StIdle);
   assign cfg_err = cfg_err_q;

   always_comb begin
      state_d         = state_q;
      w_d             = w_q;
      s_d             = s_q;
      e_len_d         = e_len_q;
      cnt_d           = cnt_q;
      e_d             = e_q;
      tap_d           = tap_q;
      cfg_err_d       = 1'b0;
      in_ready        = 1'b0;
      out_valid       = 1'b0;
      out_data        = '0;
      done            = 1'b0;
      pe_en           = 1'b0;
      pe_addr_ifmap   = '0;
      pe_addr_filter  = '0;
      pe_addr_psum    = '0;
      pe_wr_en_ifmap  = 1'b0;
      pe_input_ifmap  = '0;
      pe_wr_en_filter = 1'b0;
      pe_input_filter = '0;
      pe_wr_en_psum   = 1'b0;
      pe_input_psum   = '0;

      case (state_q)
         StIdle: begin
            if (start) begin
               if (cfg_bad) begin
                  cfg_err_d = 1'b1;
               end else begin
                  w_d     = cfg_w;
                  s_d     = cfg_s;
                  e_len_d = cfg_w - cfg_s + 4'd1;
                  cnt_d   = '0;
                  e_d     = '0;
                  tap_d   = '0;
                  state_d = StLoadIf;
               end
            end
         end
         StLoadIf: begin
            in_ready       = 1'b1;
            pe_wr_en_ifmap = in_valid;
            pe_addr_ifmap  = cnt_q;
            pe_input_ifmap = in_data;
            if (in_valid) begin
               if (cnt_q == w_q - 4'd1) begin
                  cnt_d   = '0;
                  state_d = StLoadFlt;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         StLoadFlt: begin
            in_ready        = 1'b1;
            pe_wr_en_filter = in_valid;
            pe_addr_filter  = {4'b0, cnt_q};
            pe_input_filter = in_data;
            if (in_valid) begin
               if (cnt_q == s_q - 4'd1) begin
                  cnt_d   = '0;
                  e_d     = '0;
                  state_d = StClr;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         StClr: begin
            pe_wr_en_psum = 1'b1;
            pe_addr_psum  = {1'b0, e_q};
            if (e_q == e_len_q - 4'd1) begin
               e_d     = '0;
               tap_d   = '0;
               state_d = StMac;
            end else begin
               e_d = e_q + 4'd1;
            end
         end
         StMac: begin
            pe_en          = 1'b1;
            pe_addr_ifmap  = e_q + tap_q;
            pe_addr_filter = {4'b0, tap_q};
            pe_addr_psum   = {1'b0, e_q};
            state_d        = StWb;
         end
         StWb: begin
            // The accumulator holds while pe_en is low, so a stalled WB rewrites the same value.
            pe_wr_en_psum = 1'b1;
            pe_addr_psum  = {1'b0, e_q};
            pe_input_psum = pe_output_psum;
            if (tap_q != s_q - 4'd1) begin
               tap_d   = tap_q + 4'd1;
               state_d = StMac;
            end else begin
               out_valid = 1'b1;
               out_data  = pe_output_psum;
               if (out_ready) begin
                  tap_d = '0;
                  if (e_q == e_len_q - 4'd1) begin
                     state_d = StDone;
                  end else begin
                     e_d     = e_q + 4'd1;
                     state_d = StMac;
                  end
               end
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule
